// File: rtl/comparador_serial_i_d.sv
// Bit-serial MSB-first magnitude comparator with a start/done handshake.
// Tracks EQ/GT/LT across WIDTH accepted bit pairs and registers A>=B, A>B and A==B.
module comparador_serial_i_d #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_p,
  input  logic b_p,
  output logic busy,
  output logic done,
  output logic result_valid,
  output logic p_x,
  output logic a_gt_b,
  output logic a_eq_b
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

  state_t        state_q, state_d;
  rel_t          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          px_q, px_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rel_q   <= REL_EQ;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      px_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      px_q    <= px_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  // Accepting start (from IDLE or DONE) also retracts the previous result.
  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    px_d    = px_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CMP;
          rel_d   = REL_EQ;
          cnt_d   = '0;
          valid_d = 1'b0;
          px_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (bit_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (rel_q == REL_EQ && a_p && !b_p) begin
            rel_d = REL_GT;
          end else if (rel_q == REL_EQ && !a_p && b_p) begin
            rel_d = REL_LT;
          end
          // The final pair may still decide the relation, so decode from rel_d.
          if (cnt_q == LAST) begin
            state_d = DONE;
            valid_d = 1'b1;
            px_d    = (rel_d != REL_LT);
            gt_d    = (rel_d == REL_GT);
            eq_d    = (rel_d == REL_EQ);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q == CMP);
  assign done         = (state_q == DONE);
  assign result_valid = valid_q;
  assign p_x          = px_q;
  assign a_gt_b       = gt_q;
  assign a_eq_b       = eq_q;

endmodule

// File: tb/tb_comparador_serial_i_d.sv
// Self-checking bench for comparador_serial_i_d (WIDTH=8): directed corners plus a
// random sweep, with expected results queued at start and popped at done.
module tb_comparador_serial_i_d;

  logic clk = 1'b0;
  logic rst, start, bit_valid, a_p, b_p;
  logic busy, done, result_valid, p_x, a_gt_b, a_eq_b;

  int total = 0;
  int bad = 0;
  logic [2:0] sb[$];
  logic [2:0] lastExp;

  comparador_serial_i_d #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .a_p(a_p), .b_p(b_p), .busy(busy), .done(done),
    .result_valid(result_valid), .p_x(p_x), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] refModel(input logic [7:0] a, input logic [7:0] b);
    return {a >= b, a > b, a == b};
  endfunction

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_rv"}, result_valid, 0);
    checkOutput({tag, "_res"}, {p_x, a_gt_b, a_eq_b}, 3'b000);
  endtask

  // Runs one full comparison; returns with the DUT in DONE (done visible).
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int stallAfter,
                               input int stallLen, input bit randStall, input int pulseAt,
                               input int expLat);
    int lat;
    int n;
    logic [2:0] e;
    start = 1'b1;
    bit_valid = 1'b0;
    sb.push_back(refModel(a, b));
    tick();
    lat = 1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("rv_dropped", result_valid, 0);
    checkOutput("res_cleared", {p_x, a_gt_b, a_eq_b}, 3'b000);
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1;
      a_p = a[7-i];
      b_p = b[7-i];
      start = (i == pulseAt);
      tick();
      lat++;
      start = 1'b0;
      if (i < 7) begin
        checkOutput("no_early_done", done, 0);
        n = (i == stallAfter) ? stallLen :
            ((randStall && $urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0);
        for (int s = 0; s < n; s++) begin
          bit_valid = 1'b0;
          a_p = 1'($urandom);
          b_p = 1'($urandom);
          tick();
          lat++;
          checkOutput("stall_no_done", done, 0);
        end
      end
    end
    bit_valid = 1'b0;
    checkOutput("done_pulse", done, 1);
    checkOutput("busy_in_done", busy, 0);
    checkOutput("rv_at_done", result_valid, 1);
    if (expLat > 0) checkOutput("latency", lat, expLat);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      lastExp = e;
      checkOutput("result", {p_x, a_gt_b, a_eq_b}, e);
    end
  endtask

  task automatic holdCheck(input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'($urandom);
      a_p = 1'($urandom);
      b_p = 1'($urandom);
      tick();
      checkOutput("hold_done_low", done, 0);
      checkOutput("hold_busy_low", busy, 0);
      checkOutput("hold_rv", result_valid, 1);
      checkOutput("hold_res", {p_x, a_gt_b, a_eq_b}, lastExp);
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bit_valid = 1'b0;
    a_p = 1'b0;
    b_p = 1'b0;
    lastExp = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    checkIdleZero("reset");

    // Reset mid-comparison: no done may follow even with bits streaming.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      a_p = 1'($urandom);
      b_p = 1'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdleZero("midrst");
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'b1;
      a_p = 1'($urandom);
      b_p = 1'($urandom);
      tick();
      checkOutput("midrst_no_done", done, 0);
      checkOutput("midrst_idle", busy, 0);
    end
    bit_valid = 1'b0;

    applyStimulus(8'hA5, 8'hA5, -1, 0, 1'b0, -1, 9);
    holdCheck(3);
    applyStimulus(8'h10, 8'h11, 3, 2, 1'b0, -1, 11);
    holdCheck(2);
    applyStimulus(8'h3C, 8'h3C, -1, 0, 1'b0, 2, 9);
    applyStimulus(8'h80, 8'h7F, -1, 0, 1'b0, -1, 9);
    applyStimulus(8'h00, 8'hFF, -1, 0, 1'b0, -1, 9);
    holdCheck(2);
    applyStimulus(8'hFF, 8'hFE, -1, 0, 1'b0, -1, 9);
    tick();
    checkOutput("done_one_cycle", done, 0);

    for (int k = 0; k < 1000; k++) begin
      applyStimulus(8'($urandom), 8'($urandom), -1, 0, 1'b1, -1, 0);
      holdCheck(int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparador_serial_i_d.md
# comparador_serial_i_d

Bit-serial magnitude comparator that consumes two unsigned WIDTH-bit words MSB-first (left to right). It is the left-to-right counterpart of the LSB-first iterative comparator array. It tracks a three-state relation (EQ/GT/LT) across the serial stream, counts accepted bits, and presents the final relation with a start/done handshake. It sits between serial word sources and the control logic that needs `p_x = (A >= B)`.

## Interface

- `WIDTH`, default 8; bits per word, legal range 2..32.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a new comparison; sampled only in IDLE or DONE.
- `bit_valid` input 1: `a_p`/`b_p` carry a valid bit pair this cycle.
- `a_p` input 1: current bit of word A, MSB first.
- `b_p` input 1: current bit of word B, MSB first.
- `busy` output 1: high while in CMP.
- `done` output 1: one-cycle pulse when the result becomes valid.
- `result_valid` output 1: high from `done` until the next accepted `start` or `rst`.
- `p_x` output 1: A >= B; valid when `result_valid`.
- `a_gt_b` output 1: A > B; valid when `result_valid`.
- `a_eq_b` output 1: A == B; valid when `result_valid`.

## Operation

- Control FSM has three states.
  - IDLE: waits for `start`.
  - CMP: accepts bit pairs.
  - DONE: one cycle, pulses `done`, then returns to IDLE.
- Relation register `rel` holds one of EQ, GT or LT. It is cleared to EQ when `start` is accepted.
- In CMP, each cycle with `bit_valid=1` is one accepted pair:
  - If `rel`=EQ and `a_p`=1, `b_p`=0: `rel` becomes GT.
  - If `rel`=EQ and `a_p`=0, `b_p`=1: `rel` becomes LT.
  - If `rel` is GT or LT, it is sticky; later bits are still counted but do not change it.
- Bit counter `cnt`:
  - Width `$clog2(WIDTH+1)`; cleared on `start`.
  - Increments on each accepted pair.
  - When the pair that brings `cnt` to WIDTH is accepted, the FSM goes CMP to DONE.
- There is no early termination: exactly WIDTH pairs are consumed even after GT or LT is decided.
- `bit_valid=0` in CMP stalls: `cnt` and `rel` hold, and there is no timeout.
- Outputs are registered and decoded from `rel` on entry to DONE:
  - `p_x` = (`rel` != LT).
  - `a_gt_b` = (`rel` == GT).
  - `a_eq_b` = (`rel` == EQ).
- Result outputs hold their value through IDLE until the next `start` is accepted. At that point `result_valid` drops and the result outputs clear to 0.
- `start` in CMP is ignored.
- `start` in DONE is accepted: the FSM goes DONE to CMP directly. `done` still pulses that cycle.
- `bit_valid` outside CMP is ignored. The bit pair presented in the same cycle as `start` is not sampled.

## Timing

- Reset values, taking effect on the edge where `rst`=1: FSM=IDLE, `rel`=EQ, `cnt`=0, and `busy`, `done`, `result_valid`, `p_x`, `a_gt_b`, `a_eq_b` all 0.
- `rst` has priority over every other input, including mid-CMP. A partial comparison is discarded and no `done` is produced.
- Edge sequence:
  - `start` sampled at edge k: `busy`=1 after edge k.
  - First pair can be accepted at edge k+1.
  - With `bit_valid` held high, the last pair is accepted at edge k+WIDTH.
  - After edge k+WIDTH: `done`=1, `result_valid`=1 and results valid, `busy`=0.
  - After edge k+WIDTH+1: `done`=0 and the FSM is in IDLE, unless `start` restarted it.
- Minimum latency from `start` to `done` is WIDTH+1 cycles. Each stall cycle adds one.
- Back-to-back throughput is one word per WIDTH+1 cycles, using `start` asserted during DONE.
- `done` is never high for two consecutive cycles.

## Test plan

- Reset mid-operation: start, then 3 valid bits, then `rst`=1 for 1 cycle. Required: all outputs 0 and FSM in IDLE. No `done` follows even if `bit_valid` continues.
- Equal words, WIDTH=8, A=B=0xA5, `bit_valid` held high. Required: `done` exactly 9 cycles after `start`, with `p_x`=1, `a_eq_b`=1, `a_gt_b`=0.
- Early MSB decision, A=0x80, B=0x7F. Required: `a_gt_b`=1, `p_x`=1, `a_eq_b`=0. `done` still arrives only after all 8 pairs are consumed.
- LSB-only difference with stalls, A=0x10, B=0x11, `bit_valid` deasserted for 2 cycles after bit 3. Required: `done` at cycle 11, with `p_x`=0, `a_gt_b`=0, `a_eq_b`=0.
- Handshake corners:
  - `start` pulsed again during CMP: ignored, `cnt` unaffected.
  - `start` during DONE: the next comparison (A=0x00, B=0xFF) begins immediately and gives `p_x`=0 nine cycles later.
  - `result_valid` drops the cycle after that `start`.
- Randomized sweep: 1000 random A/B pairs with random stalls. Compare `p_x`, `a_gt_b` and `a_eq_b` against a reference model, and check `result_valid` hold behaviour.
